// File: rtl/ram_frame_reader.sv
// Read-only bus master: walks WORD_COUNT words from BASE_ADDR, one read at a time,
// and streams each word out on a valid/ready interface.
module ram_frame_reader #(
   parameter logic [31:0] BASE_ADDR    = 32'd8500,
   parameter int unsigned WORD_COUNT   = 129600,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic [31:0] address,
   output logic        we,
   output logic [31:0] wd,
   input  logic [31:0] rd,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [19:0] word_index
);

   localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY);
   localparam logic [19:0] LAST_IDX = 20'(WORD_COUNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [19:0]      idx_q, idx_d;
   logic [LAT_W-1:0] lat_q, lat_d;

   // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      idx_d   = idx_q;
      lat_d   = lat_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               addr_d  = BASE_ADDR;
               idx_d   = '0;
               lat_d   = LAT_INIT;
               busy_d  = 1'b1;
            end
         end
         S_FETCH: begin
            if (lat_q == '0) begin
               data_d  = rd;
               valid_d = 1'b1;
               state_d = S_PRESENT;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         S_PRESENT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 20'd1;
                  addr_d  = BASE_ADDR + 32'(idx_q) + 32'd1;
                  lat_d   = LAT_INIT;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            addr_d  = '0;
            idx_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything, including a start seen in the same IDLE cycle.
      if (abort) begin
         state_d = S_IDLE;
         addr_d  = '0;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         idx_d   = '0;
         lat_d   = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
      end
   end

   assign address    = addr_q;
   assign we         = 1'b0;
   assign wd         = '0;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign word_index = idx_q;

endmodule

// File: tb/tb_ram_frame_reader.sv
// Directed bench: four reader instances with different parameters share the control
// inputs; each task resets them all, then checks one instance against hand-computed values.
module tb_ram_frame_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, abort, out_ready;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] addr0, rd0, data0, wd0; logic valid0, busy0, done0, we0; logic [19:0] idx0;
   logic [31:0] addr1, rd1, data1, wd1; logic valid1, busy1, done1, we1; logic [19:0] idx1;
   logic [31:0] addr2, rd2, data2, wd2; logic valid2, busy2, done2, we2; logic [19:0] idx2;
   logic [31:0] addr3, rd3, data3, wd3; logic valid3, busy3, done3, we3; logic [19:0] idx3;

   ram_frame_reader #(.BASE_ADDR(32'd8500), .WORD_COUNT(4), .READ_LATENCY(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .address(addr0), .we(we0),
      .wd(wd0), .rd(rd0), .out_data(data0), .out_valid(valid0), .out_ready(out_ready),
      .busy(busy0), .done(done0), .word_index(idx0));
   ram_frame_reader #(.BASE_ADDR(32'd8500), .WORD_COUNT(1), .READ_LATENCY(0)) u1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .address(addr1), .we(we1),
      .wd(wd1), .rd(rd1), .out_data(data1), .out_valid(valid1), .out_ready(out_ready),
      .busy(busy1), .done(done1), .word_index(idx1));
   ram_frame_reader #(.BASE_ADDR(32'd8500), .WORD_COUNT(3), .READ_LATENCY(3)) u2 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .address(addr2), .we(we2),
      .wd(wd2), .rd(rd2), .out_data(data2), .out_valid(valid2), .out_ready(out_ready),
      .busy(busy2), .done(done2), .word_index(idx2));
   ram_frame_reader #(.BASE_ADDR(32'd138095), .WORD_COUNT(5), .READ_LATENCY(1)) u3 (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .address(addr3), .we(we3),
      .wd(wd3), .rd(rd3), .out_data(data3), .out_valid(valid3), .out_ready(out_ready),
      .busy(busy3), .done(done3), .word_index(idx3));

   // RAM contents: 0xA0..0xA3 at 8500..8503, elsewhere address XOR 0x5A5A0000.
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      if (a >= 32'd8500 && a <= 32'd8503) return 32'hA0 + (a - 32'd8500);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory ports with 1, 0 and 3 cycles of read latency.
   logic [31:0] pipe2 [3];
   always @(posedge clk) begin
      rd0      <= ram_word(addr0);
      rd3      <= ram_word(addr3);
      pipe2[0] <= ram_word(addr2);
      pipe2[1] <= pipe2[0];
      pipe2[2] <= pipe2[1];
   end
   assign rd1 = ram_word(addr1);
   assign rd2 = pipe2[2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      tick; tick;
      reset = 1'b0;
   endtask

   // After return, the observed cycle is the first one with busy high.
   task automatic pulse_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      tick;
      reset = 1'b0;
      checks++; if (addr0 !== 32'd0) begin errors++; $display("FAIL reset_address: got %0d expected 0", addr0); end
      checks++; if (data0 !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", data0); end
      checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", valid0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
      checks++; if (idx0 !== 20'd0) begin errors++; $display("FAIL reset_word_index: got %0d expected 0", idx0); end
      checks++; if (we0 !== 1'b0 || wd0 !== 32'd0) begin errors++; $display("FAIL reset_we_wd: got we=%b wd=%0h expected 0/0", we0, wd0); end
   endtask

   task automatic test_basic;
      int n;
      int done_cyc;
      n = 0; done_cyc = -1;
      do_reset;
      out_ready = 1'b1;
      pulse_start;
      checks++; if (addr0 !== 32'd8500 || busy0 !== 1'b1 || valid0 !== 1'b0) begin
         errors++; $display("FAIL basic_first_cycle: got addr=%0d busy=%b valid=%b expected 8500/1/0", addr0, busy0, valid0);
      end
      for (int c = 0; c < 20; c++) begin
         if (valid0) begin
            checks++;
            if (c != 3*n+2 || data0 !== 32'hA0 + n || addr0 !== 32'd8500 + n) begin
               errors++; $display("FAIL basic_word%0d: got cyc=%0d data=%0h addr=%0d expected cyc=%0d data=%0h addr=%0d",
                                  n, c, data0, addr0, 3*n+2, 32'hA0 + n, 32'd8500 + n);
            end
            n++;
         end
         if (done0) begin
            checks++;
            if (done_cyc != -1 || c != 12 || busy0 !== 1'b1) begin
               errors++; $display("FAIL basic_done: got cyc=%0d busy=%b expected single pulse at 12 with busy=1", c, busy0);
            end
            done_cyc = c;
         end
         if (c == 13) begin
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy0); end
         end
         tick;
      end
      checks++; if (n != 4 || done_cyc != 12) begin
         errors++; $display("FAIL basic_totals: got words=%0d done_cyc=%0d expected 4/12", n, done_cyc);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] got [$];
      int stall;
      logic seen_done;
      stall = 0; seen_done = 1'b0;
      do_reset;
      pulse_start;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         if (valid0 && idx0 == 20'd1 && stall < 5) begin
            out_ready = 1'b0;
            checks++;
            if (data0 !== 32'hA1 || addr0 !== 32'd8501) begin
               errors++; $display("FAIL stall_hold: got data=%0h addr=%0d expected A1/8501", data0, addr0);
            end
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         if (valid0 && out_ready) got.push_back(data0);
         if (done0) seen_done = 1'b1;
         else tick;
      end
      checks++; if (!seen_done || stall != 5) begin
         errors++; $display("FAIL stall_done: got done=%b stall=%0d expected 1/5", seen_done, stall);
      end
      checks++; if (got.size() != 4) begin
         errors++; $display("FAIL stall_count: got %0d words expected 4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== 32'hA0 + k) begin
               errors++; $display("FAIL stall_word%0d: got %0h expected %0h", k, got[k], 32'hA0 + k);
            end
         end
      end
   endtask

   task automatic test_abort;
      logic found;
      found = 1'b0;
      do_reset;
      out_ready = 1'b1;
      pulse_start;
      for (int c = 0; c < 30; c++) begin
         if (valid0 && idx0 == 20'd2) begin found = 1'b1; break; end
         tick;
      end
      checks++; if (!found) begin errors++; $display("FAIL abort_reach_word2: got timeout expected PRESENT of word 2"); end
      out_ready = 1'b0; abort = 1'b1;
      tick;
      abort = 1'b0;
      checks++; if (valid0 !== 1'b0 || idx0 !== 20'd0 || busy0 !== 1'b0 || addr0 !== 32'd0) begin
         errors++; $display("FAIL abort_idle: got valid=%b idx=%0d busy=%b addr=%0d expected 0/0/0/0", valid0, idx0, busy0, addr0);
      end
      for (int c = 0; c < 5; c++) begin
         checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done0); end
         tick;
      end
      start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      checks++; if (busy0 !== 1'b0 || addr0 !== 32'd0) begin
         errors++; $display("FAIL start_abort_idle: got busy=%b addr=%0d expected 0/0", busy0, addr0);
      end
      pulse_start;
      checks++; if (addr0 !== 32'd8500 || busy0 !== 1'b1 || idx0 !== 20'd0) begin
         errors++; $display("FAIL abort_restart: got addr=%0d busy=%b idx=%0d expected 8500/1/0", addr0, busy0, idx0);
      end
   endtask

   task automatic test_reset_midrun;
      logic found;
      int n;
      int done_cyc;
      found = 1'b0; n = 0; done_cyc = -1;
      do_reset;
      out_ready = 1'b1;
      pulse_start;
      for (int c = 0; c < 20; c++) begin
         if (busy0 && !valid0 && idx0 == 20'd1) begin found = 1'b1; break; end
         tick;
      end
      checks++; if (!found) begin errors++; $display("FAIL rst_reach_fetch1: got timeout expected FETCH of word 1"); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++; if (addr0 !== 32'd0 || data0 !== 32'd0 || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || idx0 !== 20'd0) begin
         errors++; $display("FAIL rst_midrun: got addr=%0d data=%0h valid=%b busy=%b done=%b idx=%0d expected all 0",
                            addr0, data0, valid0, busy0, done0, idx0);
      end
      // start stays high through the whole run; it must not restart or disturb it.
      start = 1'b1;
      tick;
      for (int c = 0; c < 16; c++) begin
         if (valid0) begin
            checks++;
            if (c != 3*n+2 || data0 !== 32'hA0 + n || addr0 !== 32'd8500 + n) begin
               errors++; $display("FAIL busy_start_word%0d: got cyc=%0d data=%0h addr=%0d expected cyc=%0d data=%0h addr=%0d",
                                  n, c, data0, addr0, 3*n+2, 32'hA0 + n, 32'd8500 + n);
            end
            n++;
         end
         if (done0) begin done_cyc = c; start = 1'b0; end
         tick;
      end
      start = 1'b0;
      checks++; if (n != 4 || done_cyc != 12 || busy0 !== 1'b0) begin
         errors++; $display("FAIL busy_start_totals: got words=%0d done_cyc=%0d busy=%b expected 4/12/0", n, done_cyc, busy0);
      end
   endtask

   task automatic test_wc1_lat0;
      do_reset;
      pulse_start;
      checks++; if (addr1 !== 32'd8500 || valid1 !== 1'b0 || busy1 !== 1'b1) begin
         errors++; $display("FAIL wc1_fetch: got addr=%0d valid=%b busy=%b expected 8500/0/1", addr1, valid1, busy1);
      end
      tick;
      checks++; if (valid1 !== 1'b1 || data1 !== 32'hA0 || idx1 !== 20'd0) begin
         errors++; $display("FAIL wc1_present: got valid=%b data=%0h idx=%0d expected 1/A0/0", valid1, data1, idx1);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checks++; if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b1) begin
         errors++; $display("FAIL wc1_done: got done=%b valid=%b busy=%b expected 1/0/1", done1, valid1, busy1);
      end
      tick;
      checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++; $display("FAIL wc1_idle: got done=%b busy=%b expected 0/0", done1, busy1);
      end
   endtask

   task automatic test_latency3;
      int n;
      int done_cyc;
      n = 0; done_cyc = -1;
      do_reset;
      out_ready = 1'b1;
      pulse_start;
      for (int c = 0; c < 20; c++) begin
         if (c < 4) begin
            checks++; if (addr2 !== 32'd8500 || valid2 !== 1'b0) begin
               errors++; $display("FAIL lat3_fetch_c%0d: got addr=%0d valid=%b expected 8500/0", c, addr2, valid2);
            end
         end
         if (valid2) begin
            checks++;
            if (c != 5*n+4 || data2 !== 32'hA0 + n || addr2 !== 32'd8500 + n) begin
               errors++; $display("FAIL lat3_word%0d: got cyc=%0d data=%0h addr=%0d expected cyc=%0d data=%0h addr=%0d",
                                  n, c, data2, addr2, 5*n+4, 32'hA0 + n, 32'd8500 + n);
            end
            n++;
         end
         if (done2) done_cyc = c;
         tick;
      end
      checks++; if (n != 3 || done_cyc != 15) begin
         errors++; $display("FAIL lat3_totals: got words=%0d done_cyc=%0d expected 3/15", n, done_cyc);
      end
   endtask

   task automatic test_region_end;
      int n;
      int done_cyc;
      logic wrote;
      logic [31:0] last_addr;
      n = 0; done_cyc = -1; wrote = 1'b0; last_addr = '0;
      do_reset;
      out_ready = 1'b1;
      pulse_start;
      for (int c = 0; c < 20; c++) begin
         if (we3 !== 1'b0 || wd3 !== 32'd0) wrote = 1'b1;
         if (valid3) begin
            checks++;
            if (addr3 !== 32'd138095 + n || data3 !== 32'h5A58_1B6F + n) begin
               errors++; $display("FAIL region_word%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                  n, addr3, data3, 32'd138095 + n, 32'h5A58_1B6F + n);
            end
            last_addr = addr3;
            n++;
         end
         if (done3) done_cyc = c;
         tick;
      end
      checks++; if (n != 5 || last_addr !== 32'd138099 || done_cyc != 15) begin
         errors++; $display("FAIL region_totals: got words=%0d last_addr=%0d done_cyc=%0d expected 5/138099/15", n, last_addr, done_cyc);
      end
      checks++; if (wrote) begin errors++; $display("FAIL region_we: got write activity expected we=0 wd=0 throughout"); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_abort;
      test_reset_midrun;
      test_wc1_lat0;
      test_latency3;
      test_region_end;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
